// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage types and constants
package riscv_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_RSP, WAIT_DROP} fetch_state_t;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [1:0]  BUF_DEPTH        = 2'd2;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry FIFO of fetched {instr, pc} with flush
module fetch_buf
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);
    fetch_entry_t mem [BUF_DEPTH];
    logic rd, wr;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) mem[i] <= '0;
            rd    <= 1'b0;
            wr    <= 1'b0;
            count <= 2'd0;
        end else if (flush) begin
            rd    <= 1'b0;
            wr    <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wr] <= din;
                wr      <= ~wr;
            end
            if (pop) rd <= ~rd;
            count <= count + 2'(push) - 2'(pop);
        end
    end
    assign head = mem[rd];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch with redirect and 2-entry decode buffer
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] IAddr,
    output logic        IReq,
    input  logic        IReady,
    input  logic [31:0] IRdata,
    input  logic        IRvalid,
    output logic [31:0] Instr,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        InstrValid,
    input  logic        StallD,
    input  logic        Redirect,
    input  logic [31:0] PCTarget
);
    fetch_state_t state;
    fetch_entry_t head, din;
    logic [31:0]  pc, tag;
    logic [1:0]   count;
    logic         accept, keep, pop;
    // reset gates IReq so nothing is requested while held in reset
    assign IReq       = reset && state == IDLE && count != BUF_DEPTH && !Redirect;
    assign accept     = IReq && IReady;
    assign keep       = state == WAIT_RSP && IRvalid && !Redirect;
    assign InstrValid = count != 2'd0;
    assign pop        = InstrValid && !StallD && !Redirect;
    assign din        = '{instr: IRdata, pc: tag};
    assign IAddr      = pc;
    assign Instr      = head.instr;
    assign PCD        = head.pc;
    assign PCPlus4D   = head.pc + 32'd4;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
            tag   <= '0;
        end else begin
            if (Redirect) pc <= {PCTarget[31:2], 2'b00};
            else if (accept) begin
                pc  <= pc + 32'd4;
                tag <= pc;
            end
            case (state)
                IDLE:      state <= accept ? WAIT_RSP : IDLE;
                WAIT_RSP:  state <= IRvalid ? IDLE : (Redirect ? WAIT_DROP : WAIT_RSP);
                WAIT_DROP: state <= IRvalid ? IDLE : WAIT_DROP;
                default:   state <= IDLE;
            endcase
        end
    end
    fetch_buf u_buf (
        .clk   (clk),
        .reset (reset),
        .push  (keep),
        .pop   (pop),
        .flush (Redirect),
        .din   (din),
        .head  (head),
        .count (count)
    );
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 IAddr  output  32  SHALL be the word-aligned fetch address to instruction memory.
REQ-005 IReq  output  1  SHALL be the fetch request; accepted on a cycle with IReq=1 and IReady=1.
REQ-006 IReady  input  1  SHALL be the memory-can-accept-request flag.
REQ-007 IRdata  input  32  SHALL be the returned instruction word.
REQ-008 IRvalid  input  1  SHALL mark IRdata valid; arrives at least 1 cycle after acceptance.
REQ-009 Instr  output  32  SHALL be the instruction word presented to decode and immediate extension.
REQ-010 PCD  output  32  SHALL be the address of Instr.
REQ-011 PCPlus4D  output  32  SHALL be PCD+4, mod 2^32.
REQ-012 InstrValid  output  1  SHALL mark Instr/PCD/PCPlus4D valid.
REQ-013 StallD  input  1  SHALL indicate that decode does not consume this cycle.
REQ-014 Redirect  input  1  SHALL request a fetch restart at PCTarget.
REQ-015 PCTarget  input  32  SHALL be the redirect address; bits [1:0] ignored.

Function
REQ-016 State machine SHALL have states IDLE (no request outstanding), WAIT_RSP (one outstanding, keep), WAIT_DROP (one outstanding, discard).
REQ-017 At most one request SHALL be outstanding.
REQ-018 IReq SHALL be 1 iff state=IDLE, buffer count<2, Redirect=0; IAddr SHALL equal the fetch PC register.
REQ-019 On acceptance: IDLE->WAIT_RSP; fetch PC += 4 (wraps 32'hFFFF_FFFC->0); requested address captured as tag.
REQ-020 WAIT_RSP with IRvalid=1 and Redirect=0: push {IRdata, tag} into buffer; ->IDLE.
REQ-021 2-entry buffer SHALL present head on Instr/PCD; InstrValid=1 iff count>0; first valid cycle is the cycle after IRvalid.
REQ-022 Pop SHALL occur when InstrValid=1 and StallD=0; push and pop in same cycle SHALL leave count unchanged.
REQ-023 Redirect=1 SHALL, at next edge: flush buffer (count=0), load fetch PC with {PCTarget[31:2],2'b00}, WAIT_RSP->WAIT_DROP; Redirect overrides pop and push.
REQ-024 Redirect in same cycle as IRvalid SHALL discard that response and enter IDLE.
REQ-025 WAIT_DROP with IRvalid=1 SHALL discard the response and enter IDLE; a further Redirect in WAIT_DROP only updates fetch PC.
REQ-026 IRvalid in IDLE SHALL be ignored.
REQ-027 Buffer full (count=2) SHALL hold IReq=0 until a pop occurs.

Reset
REQ-028 reset=0 SHALL immediately set: state IDLE, fetch PC=RESET_PC, count=0, InstrValid=0, Instr=0, PCD=0, PCPlus4D=4, IReq=0 while reset asserted.
REQ-029 Reset asserted with a request outstanding SHALL forget it; its later IRvalid falls under REQ-026.
REQ-030 First IReq SHALL assert in the first cycle after reset deassertion with IAddr=RESET_PC.

Structure
REQ-031 Shared package riscv_pkg SHALL hold the fetch state enum, default RESET_PC, and buffer depth constant (2).
REQ-032 The buffer SHALL be a sub-module fetch_buf (2-entry FIFO of {instr, pc}, push/pop/flush, count).

Verification
REQ-033 Reset release, IReady=1, 1-cycle memory returning 32'h00500093 -> IAddr=0, then Instr=32'h00500093, PCD=0, PCPlus4D=4, InstrValid=1.
REQ-034 StallD=1 with 3 instructions available -> count saturates at 2, IReq=0; release StallD -> PCD 0,4,8 in order, no loss or duplicate.
REQ-035 Redirect to 32'h0000_0103 with request outstanding -> response discarded, next IAddr=32'h0000_0100, first new PCD=32'h100.
REQ-036 Redirect same cycle as IRvalid -> data dropped, InstrValid=0 next cycle, next IReq to target.
REQ-037 Fetch PC 32'hFFFF_FFFC -> next IAddr=0; PCPlus4D=0 for that instruction.
REQ-038 reset=0 mid-WAIT_RSP, stale IRvalid after release -> ignored, InstrValid=0, IAddr=RESET_PC.
